// File: rtl/video_timing_checker.sv
// Receive-side timing checker: measures an hsync/vsync/de stream, derives active-area
// pixel coordinates and reports lock against the configured video mode.
module video_timing_checker #(
    parameter int SCREENWIDTH      = 1280,
    parameter int SCREENHEIGHT     = 720,
    parameter int TOTALWIDTH       = 1650,
    parameter int TOTALHEIGHT      = 750,
    parameter int VIDEO_X_BITWIDTH = 11,
    parameter int VIDEO_Y_BITWIDTH = 10,
    parameter int MEAS_X_W         = 12,
    parameter int MEAS_Y_W         = 11,
    parameter int SYNC_POL         = 1,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic                        clk_pixel,
    input  logic                        reset_n,
    input  logic                        hsync,
    input  logic                        vsync,
    input  logic                        de,
    output logic                        locked,
    output logic                        no_signal,
    output logic                        meas_valid,
    output logic [MEAS_X_W-1:0]         h_total,
    output logic [MEAS_X_W-1:0]         h_active,
    output logic [MEAS_Y_W-1:0]         v_total,
    output logic [MEAS_Y_W-1:0]         v_active,
    output logic [7:0]                  err_count,
    output logic [VIDEO_X_BITWIDTH-1:0] cx,
    output logic [VIDEO_Y_BITWIDTH-1:0] cy,
    output logic                        pix_valid
);
    typedef enum logic [1:0] {ST_SEEK = 2'd0, ST_ACQ = 2'd1, ST_LOCKED = 2'd2} state_t;

    localparam int TO_W = $clog2(2 * TOTALWIDTH);
    localparam int MC_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [MEAS_X_W-1:0] TW_X    = MEAS_X_W'(TOTALWIDTH);
    localparam logic [MEAS_X_W-1:0] SW_X    = MEAS_X_W'(SCREENWIDTH);
    localparam logic [MEAS_Y_W-1:0] TH_Y    = MEAS_Y_W'(TOTALHEIGHT);
    localparam logic [MEAS_Y_W-1:0] SH_Y    = MEAS_Y_W'(SCREENHEIGHT);
    localparam logic [TO_W-1:0]     TO_FIRE = TO_W'(2 * TOTALWIDTH - 2);
    localparam logic [TO_W-1:0]     TO_MAX  = TO_W'(2 * TOTALWIDTH - 1);
    localparam logic [MC_W-1:0]     MC_LOCK = MC_W'(LOCK_FRAMES);

    function automatic logic [MEAS_X_W-1:0] sat_inc_x(input logic [MEAS_X_W-1:0] v);
        return (&v) ? v : v + MEAS_X_W'(1);
    endfunction

    function automatic logic [MEAS_Y_W-1:0] sat_inc_y(input logic [MEAS_Y_W-1:0] v);
        return (&v) ? v : v + MEAS_Y_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic hs_s1_q, vs_s1_q, de_s1_q, hs_p_q, vs_p_q, de_p_q;
    logic [MEAS_X_W-1:0] hcnt_q, line_len_q, run_cnt_q, run_len_q, line_len_d;
    logic [MEAS_Y_W-1:0] vcnt_q, vacnt_q, v_snap_q, va_snap_q;
    logic [TO_W-1:0] tcnt_q;
    logic [MC_W-1:0] mc_q, mc_inc;
    state_t state_q;
    logic h_seen_q, h_err_q, a_err_q, h_err_d, a_err_d, fend_q, first_run_q;
    logic hs_lead, vs_lead, de_rise, de_fall, timeout, match;
    logic locked_q, no_signal_q, meas_valid_q, pix_valid_q;
    logic [MEAS_X_W-1:0] h_total_q, h_active_q;
    logic [MEAS_Y_W-1:0] v_total_q, v_active_q;
    logic [7:0] err_q;
    logic [VIDEO_X_BITWIDTH-1:0] cx_q;
    logic [VIDEO_Y_BITWIDTH-1:0] cy_q;

    // Edge detection on the s1 stage and per-frame compare terms.
    always_comb begin
        hs_lead    = (SYNC_POL != 0) ? (hs_s1_q & ~hs_p_q) : (~hs_s1_q & hs_p_q);
        vs_lead    = (SYNC_POL != 0) ? (vs_s1_q & ~vs_p_q) : (~vs_s1_q & vs_p_q);
        de_rise    = de_s1_q & ~de_p_q;
        de_fall    = ~de_s1_q & de_p_q;
        line_len_d = sat_inc_x(hcnt_q);
        timeout    = ~hs_lead & (tcnt_q == TO_FIRE);
        match      = ~h_err_q & ~a_err_q & (v_snap_q == TH_Y) & (va_snap_q == SH_Y);
        mc_inc     = mc_q + MC_W'(1);
        // Errors seen on the frame-end cycle itself belong to the new frame.
        h_err_d    = (fend_q ? 1'b0 : h_err_q) | (hs_lead & h_seen_q & (line_len_d != TW_X));
        a_err_d    = (fend_q ? 1'b0 : a_err_q) | (de_fall & (run_cnt_q != SW_X));
    end

    // Input stage, measurement counters, lock FSM, timeout and coordinates.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            hs_s1_q <= 1'b0; vs_s1_q <= 1'b0; de_s1_q <= 1'b0;
            hs_p_q <= 1'b0; vs_p_q <= 1'b0; de_p_q <= 1'b0;
            hcnt_q <= '0; line_len_q <= '0; run_cnt_q <= '0; run_len_q <= '0;
            vcnt_q <= '0; vacnt_q <= '0; v_snap_q <= '0; va_snap_q <= '0;
            tcnt_q <= '0; mc_q <= '0; state_q <= ST_SEEK;
            h_seen_q <= 1'b0; h_err_q <= 1'b0; a_err_q <= 1'b0; fend_q <= 1'b0;
            first_run_q <= 1'b1;
            locked_q <= 1'b0; no_signal_q <= 1'b0; meas_valid_q <= 1'b0; pix_valid_q <= 1'b0;
            h_total_q <= '0; h_active_q <= '0; v_total_q <= '0; v_active_q <= '0;
            err_q <= 8'd0; cx_q <= '0; cy_q <= '0;
        end else begin
            hs_s1_q <= hsync; vs_s1_q <= vsync; de_s1_q <= de;
            hs_p_q <= hs_s1_q; vs_p_q <= vs_s1_q; de_p_q <= de_s1_q;

            if (hs_lead) begin
                hcnt_q   <= '0;
                h_seen_q <= 1'b1;
                if (h_seen_q) line_len_q <= line_len_d;
            end else begin
                hcnt_q <= sat_inc_x(hcnt_q);
            end
            if (de_s1_q) run_cnt_q <= de_rise ? MEAS_X_W'(1) : sat_inc_x(run_cnt_q);
            if (de_fall) run_len_q <= run_cnt_q;
            h_err_q <= h_err_d;
            a_err_q <= a_err_d;

            // A coincident hsync/de edge opens the new frame, so it is not part of the snapshot.
            if (vs_lead) begin
                vcnt_q    <= hs_lead ? MEAS_Y_W'(1) : '0;
                vacnt_q   <= de_rise ? MEAS_Y_W'(1) : '0;
                v_snap_q  <= vcnt_q;
                va_snap_q <= vacnt_q;
            end else begin
                if (hs_lead) vcnt_q <= sat_inc_y(vcnt_q);
                if (de_rise) vacnt_q <= sat_inc_y(vacnt_q);
            end
            fend_q       <= vs_lead;
            meas_valid_q <= fend_q;
            if (fend_q) begin
                h_total_q  <= line_len_q;
                h_active_q <= run_len_q;
                v_total_q  <= v_snap_q;
                v_active_q <= va_snap_q;
            end

            if (hs_lead) begin
                tcnt_q      <= '0;
                no_signal_q <= 1'b0;
            end else begin
                if (tcnt_q != TO_MAX) tcnt_q <= tcnt_q + TO_W'(1);
                if (timeout) no_signal_q <= 1'b1;
            end

            if (timeout) begin
                state_q  <= ST_SEEK;
                mc_q     <= '0;
                locked_q <= 1'b0;
                if (state_q == ST_LOCKED) err_q <= sat_inc_8(err_q);
            end else if (fend_q) begin
                case (state_q)
                    ST_SEEK: begin
                        state_q <= ST_ACQ;
                        mc_q    <= '0;
                    end
                    ST_ACQ: begin
                        if (!match) begin
                            mc_q <= '0;
                        end else if (mc_inc == MC_LOCK) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            mc_q     <= '0;
                        end else begin
                            mc_q <= mc_inc;
                        end
                    end
                    ST_LOCKED: begin
                        if (!match) begin
                            state_q  <= ST_ACQ;
                            locked_q <= 1'b0;
                            mc_q     <= '0;
                            err_q    <= sat_inc_8(err_q);
                        end
                    end
                    default: begin
                        state_q  <= ST_SEEK;
                        locked_q <= 1'b0;
                        mc_q     <= '0;
                    end
                endcase
            end

            pix_valid_q <= de_s1_q;
            if (de_rise) cx_q <= '0;
            else if (de_s1_q) cx_q <= cx_q + VIDEO_X_BITWIDTH'(1);
            if (de_rise) begin
                cy_q        <= (first_run_q | vs_lead) ? '0 : cy_q + VIDEO_Y_BITWIDTH'(1);
                first_run_q <= 1'b0;
            end else if (vs_lead) begin
                first_run_q <= 1'b1;
            end
        end
    end

    assign locked     = locked_q;
    assign no_signal  = no_signal_q;
    assign meas_valid = meas_valid_q;
    assign h_total    = h_total_q;
    assign h_active   = h_active_q;
    assign v_total    = v_total_q;
    assign v_active   = v_active_q;
    assign err_count  = err_q;
    assign cx         = cx_q;
    assign cy         = cy_q;
    assign pix_valid  = pix_valid_q;
endmodule

// File: tb/tb_video_timing_checker.sv
// Directed bench for video_timing_checker using a reduced video mode (10x5 total, 6x3 active).
module tb_video_timing_checker;
    localparam int SW = 6;
    localparam int SH = 3;
    localparam int TW = 10;
    localparam int TH = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic hsync = 1'b0, vsync = 1'b0, de = 1'b0;
    logic locked, no_signal, meas_valid, pix_valid;
    logic [11:0] h_total, h_active;
    logic [10:0] v_total, v_active;
    logic [7:0] err_count;
    logic [10:0] cx;
    logic [9:0] cy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int mv_cnt;
    logic any_lock;
    logic cap_locked;
    logic [7:0] cap_err;
    logic [11:0] cap_ht, cap_ha;
    logic [10:0] cap_vt, cap_va;

    video_timing_checker #(
        .SCREENWIDTH(SW), .SCREENHEIGHT(SH), .TOTALWIDTH(TW), .TOTALHEIGHT(TH),
        .VIDEO_X_BITWIDTH(11), .VIDEO_Y_BITWIDTH(10), .MEAS_X_W(12), .MEAS_Y_W(11),
        .SYNC_POL(1), .LOCK_FRAMES(2)
    ) dut (
        .clk_pixel(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .de(de),
        .locked(locked), .no_signal(no_signal), .meas_valid(meas_valid),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .err_count(err_count), .cx(cx), .cy(cy), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line l, pixel p: hsync on pixels 0-1, vsync on line 0, de on pixels 3..3+SW-1 of lines 1..va.
    function automatic logic [2:0] pins(input int l, input int p, input int va);
        logic hs, vs, d;
        hs = (p < 2);
        vs = (l == 0);
        d  = (l >= 1) && (l <= va) && (p >= 3) && (p < 3 + SW);
        return {hs, vs, d};
    endfunction

    task automatic drive_lines(input int first, input int last, input int va, input int stretch);
        mv_cnt = 0; any_lock = 1'b0;
        cap_locked = 1'bx; cap_err = 'x; cap_ht = 'x; cap_ha = 'x; cap_vt = 'x; cap_va = 'x;
        for (int l = first; l <= last; l++) begin
            for (int p = 0; p < ((l == stretch) ? TW + 1 : TW); p++) begin
                @(negedge clk);
                if (meas_valid === 1'b1) begin
                    mv_cnt++;
                    cap_locked = locked; cap_err = err_count;
                    cap_ht = h_total; cap_ha = h_active; cap_vt = v_total; cap_va = v_active;
                end
                if (locked === 1'b1) any_lock = 1'b1;
                {hsync, vsync, de} = pins(l, p, va);
                if (p == 0) hs_cyc = cyc;
            end
        end
    endtask

    task automatic drive_frame(input int va, input int stretch);
        drive_lines(0, TH - 1, va, stretch);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({locked, no_signal, meas_valid, pix_valid} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b want 0000", {locked, no_signal, meas_valid, pix_valid}); end
        checks++; if ({h_total, h_active} !== 24'd0) begin errors++;
            $display("FAIL reset_h: got %0d/%0d want 0/0", h_total, h_active); end
        checks++; if ({v_total, v_active} !== 22'd0) begin errors++;
            $display("FAIL reset_v: got %0d/%0d want 0/0", v_total, v_active); end
        checks++; if ({err_count, cx, cy} !== 29'd0) begin errors++;
            $display("FAIL reset_misc: got err=%0d cx=%0d cy=%0d want 0", err_count, cx, cy); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_nominal;
        drive_frame(SH, -1);
        checks++; if (mv_cnt != 1) begin errors++; $display("FAIL nom_mv_pulse: got %0d want 1", mv_cnt); end
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL nom_f1_locked: got %b want 0", cap_locked); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL nom_f2_locked: got %b want 0", cap_locked); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b1) begin errors++; $display("FAIL nom_f3_locked: got %b want 1", cap_locked); end
        checks++; if (cap_ht !== 12'(TW)) begin errors++; $display("FAIL nom_h_total: got %0d want %0d", cap_ht, TW); end
        checks++; if (cap_ha !== 12'(SW)) begin errors++; $display("FAIL nom_h_active: got %0d want %0d", cap_ha, SW); end
        checks++; if (cap_vt !== 11'(TH)) begin errors++; $display("FAIL nom_v_total: got %0d want %0d", cap_vt, TH); end
        checks++; if (cap_va !== 11'(SH)) begin errors++; $display("FAIL nom_v_active: got %0d want %0d", cap_va, SH); end
        checks++; if (cap_err !== 8'd0) begin errors++; $display("FAIL nom_err: got %0d want 0", cap_err); end
        checks++; if (mv_cnt != 1) begin errors++; $display("FAIL nom_mv_once: got %0d want 1", mv_cnt); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b1) begin errors++; $display("FAIL nom_f4_locked: got %b want 1", cap_locked); end
    endtask

    task automatic test_coords;
        logic [2:0] pd1, pd2;
        int ld1, ld2, pp1, pp2;
        pd1 = 3'b0; pd2 = 3'b0; ld1 = 0; ld2 = 0; pp1 = 0; pp2 = 0;
        for (int l = 0; l < TH; l++) begin
            for (int p = 0; p < TW; p++) begin
                @(negedge clk);
                checks++; if (pix_valid !== pd2[0]) begin errors++;
                    $display("FAIL coord_pix_valid l%0d p%0d: got %b want %b", ld2, pp2, pix_valid, pd2[0]); end
                if (pd2[0]) begin
                    checks++; if (cx !== 11'(pp2 - 3)) begin errors++;
                        $display("FAIL coord_cx l%0d p%0d: got %0d want %0d", ld2, pp2, cx, pp2 - 3); end
                    checks++; if (cy !== 10'(ld2 - 1)) begin errors++;
                        $display("FAIL coord_cy l%0d p%0d: got %0d want %0d", ld2, pp2, cy, ld2 - 1); end
                end
                pd2 = pd1; ld2 = ld1; pp2 = pp1;
                pd1 = pins(l, p, SH); ld1 = l; pp1 = p;
                {hsync, vsync, de} = pd1;
                if (p == 0) hs_cyc = cyc;
            end
        end
    endtask

    task automatic test_stretch;
        drive_frame(SH, 2);
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL str_locked: got %b want 0", cap_locked); end
        checks++; if (cap_err !== 8'd1) begin errors++; $display("FAIL str_err: got %0d want 1", cap_err); end
        checks++; if (cap_ht !== 12'(TW)) begin errors++; $display("FAIL str_h_total: got %0d want %0d", cap_ht, TW); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL str_relock1: got %b want 0", cap_locked); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b1) begin errors++; $display("FAIL str_relock2: got %b want 1", cap_locked); end
    endtask

    task automatic test_timeout;
        logic found, lk_at;
        logic [7:0] err_at;
        int got;
        found = 1'b0; lk_at = 1'bx; err_at = 'x; got = -1;
        {hsync, vsync, de} = 3'b000;
        for (int i = 0; i < 4 * TW && !found; i++) begin
            @(negedge clk);
            if (no_signal === 1'b1) begin
                found = 1'b1; got = cyc - hs_cyc - 1; lk_at = locked; err_at = err_count;
            end
        end
        checks++; if (!found || got != 2 * TW) begin errors++;
            $display("FAIL to_delay: got %0d want %0d clocks", got, 2 * TW); end
        checks++; if (lk_at !== 1'b0) begin errors++; $display("FAIL to_locked: got %b want 0", lk_at); end
        checks++; if (err_at !== 8'd2) begin errors++; $display("FAIL to_err: got %0d want 2", err_at); end
        drive_frame(SH, -1);
        checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", no_signal); end
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL to_seek: got %b want 0", cap_locked); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL to_acq: got %b want 0", cap_locked); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b1) begin errors++; $display("FAIL to_relock: got %b want 1", cap_locked); end
    endtask

    task automatic test_midreset;
        drive_lines(0, 1, SH, -1);
        checks++; if (cap_locked !== 1'b1) begin errors++; $display("FAIL mr_prelock: got %b want 1", cap_locked); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if ({locked, no_signal, meas_valid, pix_valid} !== 4'b0) begin errors++;
            $display("FAIL mr_flags: got %b want 0000", {locked, no_signal, meas_valid, pix_valid}); end
        checks++; if ({h_total, h_active, v_total, v_active} !== 46'd0) begin errors++;
            $display("FAIL mr_meas: got %0d/%0d/%0d/%0d want 0", h_total, h_active, v_total, v_active); end
        checks++; if ({err_count, cx, cy} !== 29'd0) begin errors++;
            $display("FAIL mr_misc: got err=%0d cx=%0d cy=%0d want 0", err_count, cx, cy); end
        reset_n = 1'b1;
        drive_lines(2, TH - 1, SH, -1);
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b0 || mv_cnt != 1) begin errors++;
            $display("FAIL mr_seek: got locked=%b mv=%0d want 0/1", cap_locked, mv_cnt); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL mr_acq: got %b want 0", cap_locked); end
        drive_frame(SH, -1);
        checks++; if (cap_locked !== 1'b1) begin errors++; $display("FAIL mr_relock: got %b want 1", cap_locked); end
        checks++; if (cap_err !== 8'd0) begin errors++; $display("FAIL mr_err: got %0d want 0", cap_err); end
    endtask

    task automatic test_saturate;
        logic lock_seen;
        int exp_err;
        lock_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive_frame(SH - 1, -1);
            if (i >= 2 && any_lock) lock_seen = 1'b1;
        end
        checks++; if (lock_seen !== 1'b0) begin errors++; $display("FAIL sat_never_lock: got %b want 0", lock_seen); end
        checks++; if (cap_err !== 8'd1) begin errors++; $display("FAIL sat_first_loss: got %0d want 1", cap_err); end
        for (int i = 0; i < 300; i++) begin
            drive_frame(SH, -1);
            exp_err = (1 + i > 255) ? 255 : 1 + i;
            checks++; if (cap_err !== 8'(exp_err)) begin errors++;
                $display("FAIL sat_err_%0d: got %0d want %0d", i, cap_err, exp_err); end
            drive_frame(SH, -1);
            drive_frame(SH - 1, -1);
            checks++; if (cap_locked !== 1'b1) begin errors++;
                $display("FAIL sat_lock_%0d: got %b want 1", i, cap_locked); end
        end
        drive_frame(SH, -1);
        checks++; if (cap_err !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", cap_err); end
        checks++; if (cap_locked !== 1'b0) begin errors++; $display("FAIL sat_final_lock: got %b want 0", cap_locked); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_nominal();
        test_coords();
        test_stretch();
        test_timeout();
        test_midreset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
